// File: rtl/noc_local_rx_unit.sv
// noc_local_rx_unit
// Ejection-side receive stage between the router local output port and the
// tile's compute endpoint. Incoming flits are queued in a small FIFO, then
// header/data/tail framing is parsed from the FIFO head. Payload flits go
// out as a valid/ready stream. Once per packet the unit reports the source
// ID, the payload length and the framing-error flags.
//
// Ports:
//   noc_clk, noc_rst        clock, asynchronous active-high reset
//   in_valid/in_ready       flit handshake from the router local port
//   in_flit                 flit, DATA_W bits
//   in_is_header/in_is_tail framing sideband
//   pl_valid/pl_ready       payload handshake toward the endpoint
//   pl_data                 payload flit
//   pkt_done                one-cycle pulse when a packet closes
//   pkt_src_x/pkt_src_y     source of the last closed packet
//   pkt_len                 payload flit count of the last closed packet
//   pkt_err                 error flags of the last closed packet:
//                           [0] header magic, [1] wrong destination,
//                           [2] bad tail, [3] truncated by a new header
//   pkt_cnt                 packets closed since reset (wraps)
module noc_local_rx_unit #(
  parameter int unsigned        DATA_W = 64,
  parameter int unsigned        ID_X_W = 4,
  parameter int unsigned        ID_Y_W = 4,
  parameter logic [ID_X_W-1:0]  MY_X   = '0,
  parameter logic [ID_Y_W-1:0]  MY_Y   = '0,
  parameter int unsigned        DEPTH  = 4,
  parameter logic [7:0]         HEAD_H = 8'hAA,
  parameter logic [7:0]         HEAD_E = 8'h55,
  parameter logic [7:0]         TAIL_H = 8'hCC,
  parameter logic [7:0]         TAIL_E = 8'h33
) (
  input  logic              noc_clk,
  input  logic              noc_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_flit,
  input  logic              in_is_header,
  input  logic              in_is_tail,
  output logic              pl_valid,
  input  logic              pl_ready,
  output logic [DATA_W-1:0] pl_data,
  output logic              pkt_done,
  output logic [ID_X_W-1:0] pkt_src_x,
  output logic [ID_Y_W-1:0] pkt_src_y,
  output logic [7:0]        pkt_len,
  output logic [3:0]        pkt_err,
  output logic [15:0]       pkt_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = DATA_W + 2;

  // Field positions inside a header/tail flit, MSB first after the H magic.
  localparam int unsigned SxMsb = DATA_W - 9;
  localparam int unsigned SyMsb = SxMsb - ID_X_W;
  localparam int unsigned DxMsb = SyMsb - ID_Y_W;
  localparam int unsigned DyMsb = DxMsb - ID_X_W;

  typedef enum logic [0:0] {StHead, StBody} state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop, empty;

  assign in_ready = (count_q != CntW'(DEPTH)) && !noc_rst;
  assign push     = in_valid && in_ready;
  assign empty    = (count_q == '0);

  always_ff @(posedge noc_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_is_header, in_is_tail, in_flit};
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO head decode
  // ---------------------------------------------------------------------------
  logic [EntW-1:0]   hd;
  logic              hd_hdr, hd_tail;
  logic [DATA_W-1:0] hd_flit;
  logic [ID_X_W-1:0] hd_sx, hd_dx;
  logic [ID_Y_W-1:0] hd_sy, hd_dy;
  logic              head_magic_bad, tail_magic_bad, dst_bad;

  assign hd      = mem_q[rd_ptr_q];
  assign hd_hdr  = hd[EntW-1];
  assign hd_tail = hd[EntW-2];
  assign hd_flit = hd[DATA_W-1:0];
  assign hd_sx   = hd_flit[SxMsb -: ID_X_W];
  assign hd_sy   = hd_flit[SyMsb -: ID_Y_W];
  assign hd_dx   = hd_flit[DxMsb -: ID_X_W];
  assign hd_dy   = hd_flit[DyMsb -: ID_Y_W];

  assign head_magic_bad = (hd_flit[DATA_W-1 -: 8] != HEAD_H) || (hd_flit[7:0] != HEAD_E);
  assign tail_magic_bad = (hd_flit[DATA_W-1 -: 8] != TAIL_H) || (hd_flit[7:0] != TAIL_E);
  assign dst_bad        = (hd_dx != MY_X) || (hd_dy != MY_Y);

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ID_X_W-1:0] src_x_q, src_x_d;
  logic [ID_Y_W-1:0] src_y_q, src_y_d;
  logic [7:0]        len_q, len_d;
  logic [3:0]        err_q, err_d;

  logic              close;
  logic [ID_X_W-1:0] close_src_x;
  logic [ID_Y_W-1:0] close_src_y;
  logic [7:0]        close_len;
  logic [3:0]        close_err;

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    pl_valid    = 1'b0;
    close       = 1'b0;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    len_d       = len_q;
    err_d       = err_q;
    close_src_x = src_x_q;
    close_src_y = src_y_q;
    close_len   = len_q;
    close_err   = err_q;

    if (!empty) begin
      unique case (state_q)
        StHead: begin
          // Headers start a packet; anything else here is stray and dropped.
          pop = 1'b1;
          if (hd_hdr) begin
            src_x_d = hd_sx;
            src_y_d = hd_sy;
            len_d   = '0;
            err_d   = {2'b00, dst_bad, head_magic_bad};
            if (hd_tail) begin
              close       = 1'b1;
              close_src_x = hd_sx;
              close_src_y = hd_sy;
              close_len   = '0;
              close_err   = {2'b00, dst_bad, head_magic_bad};
            end else begin
              state_d = StBody;
            end
          end
        end
        StBody: begin
          if (hd_hdr) begin
            // Truncated packet: leave the new header for StHead next cycle.
            close     = 1'b1;
            close_err = err_q | 4'b1000;
            state_d   = StHead;
          end else if (hd_tail) begin
            pop       = 1'b1;
            close     = 1'b1;
            close_err = err_q | {1'b0,
                                 tail_magic_bad || (hd_sx != src_x_q) || (hd_sy != src_y_q),
                                 2'b00};
            state_d   = StHead;
          end else begin
            pl_valid = 1'b1;
            if (pl_ready) begin
              pop = 1'b1;
              if (len_q != 8'hFF) begin
                len_d = len_q + 8'd1;
              end
            end
          end
        end
        default: state_d = StHead;
      endcase
    end
  end

  // Head entry cannot change until it is popped, so pl_data holds under backpressure.
  assign pl_data = hd_flit;

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q <= StHead;
      src_x_q <= '0;
      src_y_q <= '0;
      len_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-packet report, registered one cycle after the close decision
  // ---------------------------------------------------------------------------
  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      pkt_done  <= 1'b0;
      pkt_src_x <= '0;
      pkt_src_y <= '0;
      pkt_len   <= '0;
      pkt_err   <= '0;
      pkt_cnt   <= '0;
    end else begin
      pkt_done <= close;
      if (close) begin
        pkt_src_x <= close_src_x;
        pkt_src_y <= close_src_y;
        pkt_len   <= close_len;
        pkt_err   <= close_err;
        pkt_cnt   <= pkt_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_noc_local_rx_unit.sv
// Self-checking bench for noc_local_rx_unit. Expected payload flits and
// packet reports are queued when stimulus is driven and compared when the
// DUT produces them (sampled on the falling clock edge).
module tb_noc_local_rx_unit;

  logic        noc_clk = 1'b0;
  logic        noc_rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_flit;
  logic        in_is_header;
  logic        in_is_tail;
  logic        pl_valid;
  logic        pl_ready;
  logic [63:0] pl_data;
  logic        pkt_done;
  logic [3:0]  pkt_src_x;
  logic [3:0]  pkt_src_y;
  logic [7:0]  pkt_len;
  logic [3:0]  pkt_err;
  logic [15:0] pkt_cnt;

  noc_local_rx_unit dut (
    .noc_clk      (noc_clk),
    .noc_rst      (noc_rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flit      (in_flit),
    .in_is_header (in_is_header),
    .in_is_tail   (in_is_tail),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .pl_data      (pl_data),
    .pkt_done     (pkt_done),
    .pkt_src_x    (pkt_src_x),
    .pkt_src_y    (pkt_src_y),
    .pkt_len      (pkt_len),
    .pkt_err      (pkt_err),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [3:0] sx;
    logic [3:0] sy;
    logic [7:0] len;
    logic [3:0] err;
  } pkt_t;

  logic [63:0] pl_q [$];
  pkt_t        pkt_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_beats  = 0;
  int          n_done   = 0;
  int          exp_cnt  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] mk(input logic [7:0] h, input logic [3:0] sx,
                                     input logic [3:0] sy, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic [7:0] e);
    return {h, sx, sy, dx, dy, 32'h0, e};
  endfunction

  task automatic expect_pkt(input logic [3:0] sx, input logic [3:0] sy,
                            input logic [7:0] len, input logic [3:0] err);
    pkt_t p;
    p.sx = sx; p.sy = sy; p.len = len; p.err = err;
    pkt_q.push_back(p);
  endtask

  task automatic mon_step();
    pkt_t p;
    logic [63:0] d;
    if (!noc_rst) begin
      if (pl_valid && pl_ready) begin
        n_beats++;
        if (pl_q.size() == 0) check_eq("pl_unexpected", 1, 0);
        else begin
          d = pl_q.pop_front();
          check_eq("pl_data", pl_data, d);
        end
      end
      if (pkt_done) begin
        n_done++;
        if (pkt_q.size() == 0) check_eq("pkt_unexpected", 1, 0);
        else begin
          p = pkt_q.pop_front();
          exp_cnt++;
          check_eq("pkt_src_x", pkt_src_x, p.sx);
          check_eq("pkt_src_y", pkt_src_y, p.sy);
          check_eq("pkt_len", pkt_len, p.len);
          check_eq("pkt_err", pkt_err, p.err);
          check_eq("pkt_cnt", pkt_cnt, exp_cnt);
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the flit was accepted.
  task automatic send(input logic [63:0] f, input logic h, input logic t);
    int k = 0;
    in_valid = 1'b1; in_flit = f; in_is_header = h; in_is_tail = t;
    @(negedge noc_clk);
    while (!in_ready && k < 200) begin
      @(negedge noc_clk);
      k++;
    end
    if (k >= 200) check_eq("send_timeout", 1, 0);
    @(posedge noc_clk); #1;
    in_valid = 1'b0; in_is_header = 1'b0; in_is_tail = 1'b0;
  endtask

  task automatic send_data(input logic [63:0] d);
    pl_q.push_back(d);
    send(d, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((pl_q.size() != 0 || pkt_q.size() != 0) && k < budget) begin
      @(posedge noc_clk);
      k++;
    end
    repeat (4) @(posedge noc_clk);
    #1;
    check_eq("drain_left", pl_q.size() + pkt_q.size(), 0);
  endtask

  task automatic do_reset();
    noc_rst = 1'b1;
    repeat (2) @(posedge noc_clk);
    #1;
    noc_rst = 1'b0;
    exp_cnt = 0;
    pl_q.delete();
    pkt_q.delete();
    @(posedge noc_clk); #1;
  endtask

  initial begin
    noc_rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_is_header = 1'b0;
    in_is_tail = 1'b0; pl_ready = 1'b0;
    fork
      forever begin
        @(negedge noc_clk);
        mon_step();
      end
    join_none

    repeat (3) @(posedge noc_clk);
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_pl_valid", pl_valid, 0);
    check_eq("rst_pkt_done", pkt_done, 0);
    check_eq("rst_pkt_cnt", pkt_cnt, 0);
    check_eq("rst_pkt_len", pkt_len, 0);
    check_eq("rst_pkt_err", pkt_err, 0);
    check_eq("rst_pkt_src", {pkt_src_x, pkt_src_y}, 0);
    noc_rst = 1'b0;
    @(posedge noc_clk); #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    // Basic packet, endpoint always ready.
    pl_ready = 1'b1; n_beats = 0;
    expect_pkt(4'd1, 4'd1, 8'd3, 4'b0000);
    send(mk(8'hAA, 4'd1, 4'd1, 4'd0, 4'd0, 8'h55), 1'b1, 1'b0);
    repeat (3) send_data(64'hFFFF_FFFF_FFFF_FFFF);
    send(mk(8'hCC, 4'd1, 4'd1, 4'd0, 4'd0, 8'h33), 1'b0, 1'b1);
    wait_drain(100);
    check_eq("t1_beats", n_beats, 3);
    check_eq("t1_cnt", pkt_cnt, 1);

    // Backpressure: FIFO fills, head stays stable, then drains.
    do_reset();
    pl_ready = 1'b0; n_beats = 0;
    expect_pkt(4'd1, 4'd1, 8'd3, 4'b0000);
    send(mk(8'hAA, 4'd1, 4'd1, 4'd0, 4'd0, 8'h55), 1'b1, 1'b0);
    send_data(64'h1111_0000_0000_0001);
    send_data(64'h2222_0000_0000_0002);
    send_data(64'h3333_0000_0000_0003);
    send(mk(8'hCC, 4'd1, 4'd1, 4'd0, 4'd0, 8'h33), 1'b0, 1'b1);
    @(negedge noc_clk);
    check_eq("t2_full_in_ready", in_ready, 0);
    check_eq("t2_pl_valid", pl_valid, 1);
    check_eq("t2_pl_data", pl_data, 64'h1111_0000_0000_0001);
    repeat (3) @(negedge noc_clk);
    check_eq("t2_pl_data_hold", pl_data, 64'h1111_0000_0000_0001);
    @(posedge noc_clk); #1;
    pl_ready = 1'b1;
    wait_drain(100);
    check_eq("t2_beats", n_beats, 3);
    check_eq("t2_in_ready", in_ready, 1);

    // Wrong destination, then bad tail magic.
    expect_pkt(4'd1, 4'd2, 8'd1, 4'b0010);
    send(mk(8'hAA, 4'd1, 4'd2, 4'd2, 4'd0, 8'h55), 1'b1, 1'b0);
    send_data(64'hDEAD_BEEF_0000_0010);
    send(mk(8'hCC, 4'd1, 4'd2, 4'd2, 4'd0, 8'h33), 1'b0, 1'b1);
    expect_pkt(4'd3, 4'd4, 8'd1, 4'b0100);
    send(mk(8'hAA, 4'd3, 4'd4, 4'd0, 4'd0, 8'h55), 1'b1, 1'b0);
    send_data(64'hDEAD_BEEF_0000_0020);
    send(mk(8'hCC, 4'd3, 4'd4, 4'd0, 4'd0, 8'h00), 1'b0, 1'b1);
    wait_drain(100);

    // Truncated packet followed by a clean one.
    expect_pkt(4'd2, 4'd3, 8'd1, 4'b1000);
    expect_pkt(4'd1, 4'd1, 8'd1, 4'b0000);
    send(mk(8'hAA, 4'd2, 4'd3, 4'd0, 4'd0, 8'h55), 1'b1, 1'b0);
    send_data(64'hA5A5_0000_0000_0030);
    send(mk(8'hAA, 4'd1, 4'd1, 4'd0, 4'd0, 8'h55), 1'b1, 1'b0);
    send_data(64'hA5A5_0000_0000_0031);
    send(mk(8'hCC, 4'd1, 4'd1, 4'd0, 4'd0, 8'h33), 1'b0, 1'b1);
    wait_drain(100);

    // Single-flit packet, then a stray data flit that must be dropped.
    n_beats = 0; n_done = 0;
    expect_pkt(4'd5, 4'd6, 8'd0, 4'b0000);
    send(mk(8'hAA, 4'd5, 4'd6, 4'd0, 4'd0, 8'h55), 1'b1, 1'b1);
    send(64'h0BAD_0000_0000_0040, 1'b0, 1'b0);
    wait_drain(100);
    check_eq("t5_beats", n_beats, 0);
    check_eq("t5_done", n_done, 1);
    check_eq("t5_cnt", pkt_cnt, 6);

    // Reset mid-packet: partial packet vanishes, next packet is normal.
    n_done = 0;
    send(mk(8'hAA, 4'd1, 4'd1, 4'd0, 4'd0, 8'h55), 1'b1, 1'b0);
    send_data(64'hC0DE_0000_0000_0050);
    repeat (5) @(posedge noc_clk);
    #1;
    noc_rst = 1'b1;
    #1;
    check_eq("t6_rst_in_ready", in_ready, 0);
    check_eq("t6_rst_pkt_cnt", pkt_cnt, 0);
    check_eq("t6_rst_pl_valid", pl_valid, 0);
    check_eq("t6_rst_pkt_err", pkt_err, 0);
    check_eq("t6_rst_pkt_src", {pkt_src_x, pkt_src_y}, 0);
    @(posedge noc_clk); #1;
    do_reset();
    check_eq("t6_done_none", n_done, 0);
    check_eq("t6_pkt_len", pkt_len, 0);
    expect_pkt(4'd1, 4'd1, 8'd2, 4'b0000);
    send(mk(8'hAA, 4'd1, 4'd1, 4'd0, 4'd0, 8'h55), 1'b1, 1'b0);
    send_data(64'hC0DE_0000_0000_0051);
    send_data(64'hC0DE_0000_0000_0052);
    send(mk(8'hCC, 4'd1, 4'd1, 4'd0, 4'd0, 8'h33), 1'b0, 1'b1);
    wait_drain(100);
    check_eq("t6_cnt", pkt_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
